// File: rtl/srl_tap_line.sv
`default_nettype none
// ============================================================================
// Module   : srl_tap_line
// Purpose  : Addressable shift register (SRL-style) with fill-tracked tap
//            valid flags. Optional output register: SRL_TAP_LINE_OUTREG_EN.
// Revision : 1.0
// ============================================================================
module srl_tap_line #(
  parameter int W     = 6,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          flush,
  input  logic [W-1:0]  d,
  input  logic [AW-1:0] a,
  output logic [W-1:0]  y,
  output logic          yv,
  output logic          full
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_one   = (AW+1)'(1);

  logic [W-1:0] stage_q [DEPTH];
  logic [AW:0]  fill_q;
  logic [AW:0]  fill_d;
  logic         tap_valid;
  logic [W-1:0] tap_data;

  // Data stages carry no reset so they can map onto SRL primitives.
  always_ff @(posedge clk) begin
    if (ce) begin
      stage_q[0] <= d;
      for (int k = 1; k < DEPTH; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  always_comb begin
    fill_d = fill_q;
    if (flush) begin
      fill_d = ce ? c_one : '0;
    end else if (ce && (fill_q != c_depth)) begin
      fill_d = fill_q + c_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign tap_valid = ({1'b0, a} < fill_q);
  assign tap_data  = tap_valid ? stage_q[a] : '0;
  assign full      = (fill_q == c_depth);

`ifdef SRL_TAP_LINE_OUTREG_EN
  logic [W-1:0] y_q;
  logic         yv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q  <= '0;
      yv_q <= 1'b0;
    end else begin
      y_q  <= tap_data;
      yv_q <= tap_valid;
    end
  end

  assign y  = y_q;
  assign yv = yv_q;
`else
  assign y  = tap_data;
  assign yv = tap_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_srl_tap_line.sv
`default_nettype none
// ============================================================================
// Module   : tb_srl_tap_line
// Purpose  : Scoreboard bench for srl_tap_line (W=6, DEPTH=16).
// Revision : 1.0
// ============================================================================
module tb_srl_tap_line;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic       flush;
  logic [5:0] d;
  logic [3:0] a;
  logic [5:0] y;
  logic       yv;
  logic       full;

  srl_tap_line #(.W(6), .DEPTH(16), .AW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .flush (flush),
    .d     (d),
    .a     (a),
    .y     (y),
    .yv    (yv),
    .full  (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] y;
    logic       yv;
    logic       full;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  event  sample_ev;
  int    checks = 0;
  int    errors = 0;

  // Monitor: compares the DUT outputs against the oldest queued expectation.
  always @(sample_ev) begin
    exp_t  e;
    string n;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_underflow: sample with no expectation");
    end else begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (y !== e.y || yv !== e.yv || full !== e.full) begin
        errors++;
        $display("FAIL %s: got y=%h yv=%b full=%b, expected y=%h yv=%b full=%b",
                 n, y, yv, full, e.y, e.yv, e.full);
      end
    end
  end

  task automatic expect_now(input string n, input logic [5:0] ey,
                            input logic eyv, input logic efull);
    exp_t e;
    e.y = ey; e.yv = eyv; e.full = efull;
    exp_q.push_back(e);
    name_q.push_back(n);
    -> sample_ev;
    #0;
  endtask

  // Set the tap address and sample once the read path has settled.
  task automatic check(input string n, input logic [3:0] addr, input logic [5:0] ey,
                       input logic eyv, input logic efull);
    a = addr;
`ifdef SRL_TAP_LINE_OUTREG_EN
    @(posedge clk); #1;
`endif
    @(negedge clk);
    expect_now(n, ey, eyv, efull);
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic [5:0] din, input logic fl);
    ce = 1'b1; flush = fl; d = din;
    @(posedge clk); #1;
    ce = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ce = 1'b0; flush = 1'b0; d = '0; a = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state and initial fill
    check("reset_a0", 4'd0, 6'h00, 1'b0, 1'b0);
    pulse(6'h11, 1'b0);
    pulse(6'h12, 1'b0);
    pulse(6'h13, 1'b0);
    check("fill_a0", 4'd0, 6'h13, 1'b1, 1'b0);
    check("fill_a1", 4'd1, 6'h12, 1'b1, 1'b0);
    check("fill_a3", 4'd3, 6'h00, 1'b0, 1'b0);
    check("fill_a15", 4'd15, 6'h00, 1'b0, 1'b0);
    check("fill_a0b", 4'd0, 6'h13, 1'b1, 1'b0);

    // Address change 0 -> 2: read latency on the address
    a = 4'd2;
    @(negedge clk);
`ifdef SRL_TAP_LINE_OUTREG_EN
    expect_now("outreg_same_cycle", 6'h13, 1'b1, 1'b0);
    @(negedge clk);
    expect_now("outreg_next_cycle", 6'h11, 1'b1, 1'b0);
`else
    expect_now("comb_same_cycle", 6'h11, 1'b1, 1'b0);
`endif
    @(posedge clk); #1;

    // Flush without ce empties the line; then saturate with 1..20
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flushed_a0", 4'd0, 6'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      pulse(6'(i), 1'b0);
      if (i == 15) check("sat_p15", 4'd15, 6'h00, 1'b0, 1'b0);
      if (i == 16) check("sat_p16", 4'd15, 6'd1, 1'b1, 1'b1);
    end
    check("sat_end_a15", 4'd15, 6'd5, 1'b1, 1'b1);
    check("sat_end_a0", 4'd0, 6'd20, 1'b1, 1'b1);

    // Hold: ce low while sweeping every tap
    for (int t = 0; t < 16; t++) begin
      check($sformatf("hold_a%0d", t), 4'(t), 6'(20 - t), 1'b1, 1'b1);
    end

    // Flush together with ce
    pulse(6'h2A, 1'b1);
    check("flush_ce_a0", 4'd0, 6'h2A, 1'b1, 1'b0);
    check("flush_ce_a1", 4'd1, 6'h00, 1'b0, 1'b0);

    // Build up to fill=9
    for (int i = 0; i < 8; i++) pulse(6'(6'h30 + i), 1'b0);
    check("fill9_a8", 4'd8, 6'h2A, 1'b1, 1'b0);
    check("fill9_a9", 4'd9, 6'h00, 1'b0, 1'b0);
    check("fill9_a0", 4'd0, 6'h37, 1'b1, 1'b0);

    // Asynchronous reset between clock edges
    a = 4'd0;
`ifdef SRL_TAP_LINE_OUTREG_EN
    @(posedge clk); #1;
`endif
    @(negedge clk);
    expect_now("pre_async_rst", 6'h37, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 expect_now("async_rst", 6'h00, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_a0", 4'd0, 6'h00, 1'b0, 1'b0);
    pulse(6'h15, 1'b0);
    check("refill_a0", 4'd0, 6'h15, 1'b1, 1'b0);
    check("refill_a1", 4'd1, 6'h00, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
